// File: rtl/ifport_nest_rr_mux.sv
// NCH-channel valid/ready concatenator: round-robin grant into a DEPTH-entry
// FIFO, each output beat tagged with the channel it came from.

module ifport_nest_rr_lane #(
  parameter int DW = 8
) (
  input  logic          i_sel,
  input  logic          i_can_push,
  input  logic [DW-1:0] i_data,
  output logic          o_ready,
  output logic [DW-1:0] o_data
);
  assign o_ready = i_sel & i_can_push;
  // Zero when not selected so the top can OR all lanes into one bus.
  assign o_data  = i_sel ? i_data : '0;
endmodule

module ifport_nest_rr_mux #(
  parameter  int NCH   = 4,
  parameter  int DW    = 8,
  parameter  int DEPTH = 2,
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNTW  = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  input  logic [NCH*DW-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [CW-1:0]     out_chan,
  output logic [CNTW-1:0]   count
);

  logic [CW-1:0]             r_ptr;
  logic [AW-1:0]             r_wr, r_rd;
  logic [CNTW-1:0]           r_count;
  logic [DEPTH-1:0][DW-1:0]  r_mem_d;
  logic [DEPTH-1:0][CW-1:0]  r_mem_c;
  logic [DW-1:0]             r_hold_d;
  logic [CW-1:0]             r_hold_c;

  logic                      w_gnt_vld;
  logic [CW-1:0]             w_gnt;
  logic [CW:0]               w_idx;
  logic [NCH-1:0]            w_vsh;
  logic [NCH-1:0]            w_sel;
  logic [NCH-1:0][DW-1:0]    w_lane_d;
  logic [DW-1:0]             w_push_d;
  logic [CW-1:0]             w_ptr_nxt;
  logic                      w_can_push, w_push, w_pop;

  // Rotating priority scan starting at r_ptr; first asserted valid wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_idx     = '0;
    w_vsh     = '0;
    for (int k = 0; k < NCH; k++) begin
      w_idx = {1'b0, r_ptr} + (CW+1)'(k);
      if (w_idx >= (CW+1)'(NCH)) w_idx = w_idx - (CW+1)'(NCH);
      w_vsh = in_valid >> w_idx;
      if (!w_gnt_vld && w_vsh[0]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = w_idx[CW-1:0];
      end
    end
  end

  assign out_valid  = (r_count != '0);
  assign w_pop      = out_valid & out_ready;
  assign w_can_push = (r_count < CNTW'(DEPTH)) | w_pop;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
    assign w_sel[gi] = w_gnt_vld && (w_gnt == CW'(gi));
    ifport_nest_rr_lane #(.DW(DW)) u_lane (
      .i_sel      (w_sel[gi]),
      .i_can_push (w_can_push),
      .i_data     (in_data[gi*DW +: DW]),
      .o_ready    (in_ready[gi]),
      .o_data     (w_lane_d[gi])
    );
  end

  always_comb begin
    w_push_d = '0;
    for (int i = 0; i < NCH; i++) w_push_d = w_push_d | w_lane_d[i];
  end

  assign w_push    = |(in_valid & in_ready);
  assign w_ptr_nxt = (w_gnt == CW'(NCH-1)) ? '0 : w_gnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_wr     <= '0;
      r_rd     <= '0;
      r_count  <= '0;
      r_mem_d  <= '0;
      r_mem_c  <= '0;
      r_hold_d <= '0;
      r_hold_c <= '0;
    end else begin
      if (w_push) begin
        r_mem_d[r_wr] <= w_push_d;
        r_mem_c[r_wr] <= w_gnt;
        r_wr          <= r_wr + 1'b1;
        r_ptr         <= w_ptr_nxt;
      end
      // Keep the popped head so outputs hold their last value when empty.
      if (w_pop) begin
        r_rd     <= r_rd + 1'b1;
        r_hold_d <= r_mem_d[r_rd];
        r_hold_c <= r_mem_c[r_rd];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_data = out_valid ? r_mem_d[r_rd] : r_hold_d;
  assign out_chan = out_valid ? r_mem_c[r_rd] : r_hold_c;
  assign count    = r_count;

endmodule

// File: tb/tb_ifport_nest_rr_mux.sv
// Bench for ifport_nest_rr_mux: directed scenarios plus a queue-based
// reference model that watches the default 4-channel instance every cycle.

module tb_ifport_nest_rr_mux;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic [1:0]  count;

  logic        v1, r1, ov1, or1;
  logic [15:0] d1, od1;
  logic        oc1;
  logic [2:0]  cnt1;

  int checks = 0;
  int errors = 0;

  ifport_nest_rr_mux dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_chan(out_chan), .count(count)
  );

  ifport_nest_rr_mux #(.NCH(1), .DW(16), .DEPTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1),
    .in_data(d1), .out_valid(ov1), .out_ready(or1),
    .out_data(od1), .out_chan(oc1), .count(cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: queue of {data, chan}, pointer as an integer.
  logic [9:0] m_q[$];
  logic [9:0] m_hold;
  int         m_ptr;

  function automatic int ref_grant(input logic [3:0] v, input int p);
    logic [3:0] t;
    for (int k = 0; k < 4; k++) begin
      t = v >> ((p + k) % 4);
      if (t[0]) return (p + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int g;
    logic cp, pop;
    if (!rst_n) begin
      m_q.delete();
      m_ptr  = 0;
      m_hold = '0;
    end else begin
      g   = ref_grant(in_valid, m_ptr);
      pop = (m_q.size() > 0) && out_ready;
      cp  = (m_q.size() < 2) || pop;
      if (pop) m_hold = m_q.pop_front();
      if (g >= 0 && cp) begin
        m_q.push_back({8'(in_data >> (8 * g)), 2'(g)});
        m_ptr = (g + 1) % 4;
      end
    end
  end

  always @(negedge clk) begin : monitor
    int         g;
    logic       cp;
    logic [3:0] er;
    logic [9:0] eh;
    if (rst_n) begin
      g  = ref_grant(in_valid, m_ptr);
      cp = (m_q.size() < 2) || ((m_q.size() > 0) && out_ready);
      er = (g >= 0 && cp) ? 4'(1 << g) : 4'b0;
      eh = (m_q.size() > 0) ? m_q[0] : m_hold;
      checks++;
      if ({out_valid, count, out_data, out_chan, in_ready} !==
          {(m_q.size() > 0), 2'(m_q.size()), eh, er}) begin
        errors++;
        $display("FAIL model t=%0t got v=%b cnt=%0d d=%h ch=%0d rdy=%b want v=%b cnt=%0d d=%h ch=%0d rdy=%b",
                 $time, out_valid, count, out_data, out_chan, in_ready,
                 (m_q.size() > 0), m_q.size(), eh[9:2], eh[1:0], er);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    v1 = 1'b0; d1 = '0; or1 = 1'b0;
    #12;
    checks++;
    if ({out_valid, count, out_data, out_chan, in_ready} !== 15'b0) begin
      errors++;
      $display("FAIL reset_state got v=%b cnt=%0d d=%h ch=%0d rdy=%b want all 0",
               out_valid, count, out_data, out_chan, in_ready);
    end
    in_valid = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_ready got %b want 0001", in_ready);
    end
    in_valid = '0;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    in_data   = 32'hA3A2A1A0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (!out_valid || out_chan !== 2'((k - 1) % 4) ||
          out_data !== 8'(8'hA0 + (k - 1) % 4) || count !== 2'd1) begin
        errors++;
        $display("FAIL rr_seq k=%0d got v=%b ch=%0d d=%h cnt=%0d want ch=%0d d=%h cnt=1",
                 k, out_valid, out_chan, out_data, count, (k - 1) % 4, 8'hA0 + (k - 1) % 4);
      end
    end
    #1 in_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_full_ch2();
    out_ready = 1'b0;
    in_data   = 32'h0011_0000;
    in_valid  = 4'b0100;
    tick();
    in_data = 32'h0022_0000;
    tick();
    in_data = 32'h0033_0000;
    @(negedge clk);
    checks++;
    if (count !== 2'd2 || in_ready !== 4'b0000 || out_data !== 8'h11) begin
      errors++;
      $display("FAIL full_stall got cnt=%0d rdy=%b d=%h want cnt=2 rdy=0000 d=11",
               count, in_ready, out_data);
    end
    #1 out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (count !== 2'd2 || out_data !== 8'h22) begin
      errors++;
      $display("FAIL pop_push got cnt=%0d d=%h want cnt=2 d=22", count, out_data);
    end
    #1 in_valid = '0;
    @(negedge clk);
    checks++;
    if (count !== 2'd1 || out_data !== 8'h33 || out_chan !== 2'd2) begin
      errors++;
      $display("FAIL order_33 got cnt=%0d d=%h ch=%0d want cnt=1 d=33 ch=2",
               count, out_data, out_chan);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h33) begin
      errors++;
      $display("FAIL empty_hold got v=%b d=%h want v=0 d=33", out_valid, out_data);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_r[3];
    logic [1:0] exp_c[3];
    exp_r = '{4'b1000, 4'b0001, 4'b1000};
    exp_c = '{2'd0, 2'd3, 2'd0};
    in_data = 32'h5A5A5A5A;
    #1 in_valid = 4'b0001;
    @(posedge clk);
    #1 in_valid = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== exp_r[k] || out_chan !== exp_c[k]) begin
        errors++;
        $display("FAIL wrap k=%0d got rdy=%b ch=%0d want rdy=%b ch=%0d",
                 k, in_ready, out_chan, exp_r[k], exp_c[k]);
      end
    end
    #1 in_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_backpressure();
    logic       pv, pr;
    logic [7:0] pd;
    logic [1:0] pc;
    logic [3:0] acc, nv;
    logic [31:0] nd;
    pv = 1'b0; pr = 1'b1; pd = '0; pc = '0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (pv && !pr) begin
        checks++;
        if ({out_data, out_chan} !== {pd, pc}) begin
          errors++;
          $display("FAIL hold n=%0d got d=%h ch=%0d want d=%h ch=%0d",
                   n, out_data, out_chan, pd, pc);
        end
      end
      pv = out_valid; pr = out_ready; pd = out_data; pc = out_chan;
      acc = in_valid & in_ready;
      tick();
      nv = in_valid;
      nd = in_data;
      for (int i = 0; i < 4; i++) begin
        if (!in_valid[i] || acc[i]) begin
          nv[i] = 1'($urandom_range(0, 1));
          nd[i*8 +: 8] = 8'($urandom);
        end
      end
      in_valid  = nv;
      in_data   = nd;
      out_ready = ~out_ready;
    end
    in_valid  = '0;
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_data   = 32'h44332211;
    in_valid  = 4'b0110;
    tick();
    tick();
    #3 rst_n = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || count !== 2'd0) begin
      errors++;
      $display("FAIL async_rst got v=%b cnt=%0d want v=0 cnt=0", out_valid, count);
    end
    in_valid = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rst_ptr got rdy=%b want 0001", in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (!out_valid || out_chan !== 2'd0 || out_data !== 8'h11) begin
      errors++;
      $display("FAIL post_rst got v=%b ch=%0d d=%h want v=1 ch=0 d=11",
               out_valid, out_chan, out_data);
    end
    #1 in_valid = '0;
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) tick();
  endtask

  task automatic test_nch1();
    logic [15:0] vals[5];
    for (int k = 0; k < 5; k++) vals[k] = 16'($urandom);
    or1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d1 = vals[k];
      v1 = 1'b1;
      @(negedge clk);
      checks++;
      if (r1 !== 1'b1) begin
        errors++;
        $display("FAIL nch1_ready k=%0d got %b want 1", k, r1);
      end
      tick();
    end
    d1 = vals[4];
    @(negedge clk);
    checks++;
    if (r1 !== 1'b0 || cnt1 !== 3'd4 || od1 !== vals[0]) begin
      errors++;
      $display("FAIL nch1_full got rdy=%b cnt=%0d d=%h want rdy=0 cnt=4 d=%h",
               r1, cnt1, od1, vals[0]);
    end
    #1 or1 = 1'b1;
    @(posedge clk);
    #1 v1 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (!ov1 || od1 !== vals[k] || oc1 !== 1'b0) begin
        errors++;
        $display("FAIL nch1_drain k=%0d got v=%b d=%h ch=%b want v=1 d=%h ch=0",
                 k, ov1, od1, oc1, vals[k]);
      end
    end
    @(negedge clk);
    checks++;
    if (ov1 !== 1'b0 || cnt1 !== 3'd0) begin
      errors++;
      $display("FAIL nch1_empty got v=%b cnt=%0d want v=0 cnt=0", ov1, cnt1);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_full_ch2();
    test_wrap();
    test_backpressure();
    test_async_reset();
    test_nch1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
